// File: rtl/hc74_pkg.sv
// Shared definitions for the 74xx board-level glue-logic models.
package hc74_pkg;

    // Gate count of a 74x04 package.
    localparam int HEX_WIDTH = 6;

    // Per-gate value loaded into output registers during reset.
    localparam logic HEX_RESET_BIT = 1'b0;

    // Default reset vector for a full 74x04 channel.
    localparam logic [HEX_WIDTH-1:0] HEX_RESET_VALUE = {HEX_WIDTH{HEX_RESET_BIT}};

    // Number of gates per package across the 74xx family.
    typedef enum logic [2:0] {
        GATES_1 = 3'd1,
        GATES_2 = 3'd2,
        GATES_4 = 3'd4,
        GATES_6 = 3'd6
    } gate_count_e;

endpackage

// File: rtl/hex_inverter_74x04_inverter_gate.sv
// Single NOT gate with an optional output flop for synchronous datapaths.
module inverter_gate
    import hc74_pkg::*;
#(
    parameter bit   REGISTERED = 1'b0,
    parameter logic RESET_BIT  = HEX_RESET_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y
);

    logic y_d;

    // Gate function.
    always_comb begin
        y_d = ~a;
    end

    generate
        if (REGISTERED) begin : g_reg
            logic y_q;

            // Output flop, cleared asynchronously so reset needs no clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) y_q <= RESET_BIT;
                else        y_q <= y_d;
            end

            assign y = y_q;
        end else begin : g_comb
            // Clock and reset have no role in the combinational gate.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign y = y_d;
        end
    endgenerate

endmodule

// File: rtl/hex_inverter_74x04.sv
// 74x04 hex inverter: a bused 6-gate channel and a split channel built from
// individually instantiated gates. The channels share no logic.
module hex_inverter_74x04
    import hc74_pkg::*;
#(
    parameter int               WIDTH       = HEX_WIDTH,
    parameter bit               REGISTERED  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{HEX_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_bus,
    output logic [WIDTH-1:0] y_bus,
    input  logic [WIDTH-1:0] a_split,
    output logic [WIDTH-1:0] y_split
);

    logic [WIDTH-1:0] y_bus_d;

    // Bused channel: one vector inversion.
    always_comb begin
        y_bus_d = ~a_bus;
    end

    generate
        if (REGISTERED) begin : g_bus_reg
            logic [WIDTH-1:0] y_bus_q;

            // Bused output register; reset overrides any pending capture.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) y_bus_q <= RESET_VALUE;
                else        y_bus_q <= y_bus_d;
            end

            assign y_bus = y_bus_q;
        end else begin : g_bus_comb
            assign y_bus = y_bus_d;
        end
    endgenerate

    // Split channel: one gate instance per bit, each with its own flop when
    // registered, so no bit can disturb another.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_gate
            inverter_gate #(
                .REGISTERED (REGISTERED),
                .RESET_BIT  (RESET_VALUE[i])
            ) u_gate (
                .clk   (clk),
                .rst_n (rst_n),
                .a     (a_split[i]),
                .y     (y_split[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_hex_inverter_74x04.sv
// Directed bench for hex_inverter_74x04: one combinational and one registered
// instance, driven by hand-picked vectors.
module tb_hex_inverter_74x04;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [5:0] c_a_bus, c_y_bus, c_a_split, c_y_split;
    logic [5:0] r_a_bus, r_y_bus, r_a_split, r_y_split;

    int checks   = 0;
    int failures = 0;

    hex_inverter_74x04 #(.WIDTH(6), .REGISTERED(1'b0), .RESET_VALUE(6'b000000)) u_comb (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_bus   (c_a_bus),
        .y_bus   (c_y_bus),
        .a_split (c_a_split),
        .y_split (c_y_split)
    );

    hex_inverter_74x04 #(.WIDTH(6), .REGISTERED(1'b1), .RESET_VALUE(6'b000000)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_bus   (r_a_bus),
        .y_bus   (r_y_bus),
        .a_split (r_a_split),
        .y_split (r_y_split)
    );

    // Gated clock so reset behaviour can be observed with the clock stopped.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    logic [5:0] v;

    initial begin
        clk_en    = 1'b0;
        rst_n     = 1'b0;
        c_a_bus   = 6'b000000;
        c_a_split = 6'b000000;
        r_a_bus   = 6'b000000;
        r_a_split = 6'b000000;

        // Registered outputs held at reset value with the clock stopped.
        #20;
        chk("rst_bus", r_y_bus, 6'b000000);
        chk("rst_split", r_y_split, 6'b000000);

        // Combinational bused channel truth points.
        c_a_bus = 6'b111111;
        #20;
        chk("comb_bus_ones", c_y_bus, 6'b000000);
        c_a_bus = 6'b000000;
        #20;
        chk("comb_bus_zeros", c_y_bus, 6'b111111);

        // Split channel toggles while the bused channel holds steady.
        c_a_bus   = 6'b101010;
        c_a_split = 6'b111111;
        #20;
        chk("comb_split_ones", c_y_split, 6'b000000);
        chk("comb_bus_hold0", c_y_bus, 6'b010101);
        c_a_split = 6'b000000;
        #20;
        chk("comb_split_zeros", c_y_split, 6'b111111);
        chk("comb_bus_hold1", c_y_bus, 6'b010101);

        // Walking one and walking zero across both channels.
        for (int i = 0; i < 6; i++) begin
            v         = 6'b000001 << i;
            c_a_bus   = v;
            c_a_split = v;
            #1;
            chk("walk1_bus", c_y_bus, v ^ 6'b111111);
            chk("walk1_split", c_y_split, v ^ 6'b111111);
            chk("walk1_eq", c_y_bus, c_y_split);
            v         = v ^ 6'b111111;
            c_a_bus   = v;
            c_a_split = v;
            #1;
            chk("walk0_bus", c_y_bus, v ^ 6'b111111);
            chk("walk0_split", c_y_split, v ^ 6'b111111);
            chk("walk0_eq", c_y_bus, c_y_split);
        end

        // Unknown on bit 3 only: every other output bit must be 1.
        c_a_bus   = 6'b00x000;
        c_a_split = 6'b00x000;
        #1;
        chk("x_bus_others", c_y_bus & 6'b110111, 6'b110111);
        chk("x_split_others", c_y_split & 6'b110111, 6'b110111);

        // Release reset; output must not change before the first edge.
        rst_n     = 1'b1;
        #2;
        r_a_bus   = 6'b110011;
        r_a_split = 6'b110011;
        #1;
        chk("reg_bus_not_before", r_y_bus, 6'b000000);
        chk("reg_split_not_before", r_y_split, 6'b000000);
        clk_en = 1'b1;
        @(posedge clk); #1;
        chk("reg_bus_first", r_y_bus, 6'b001100);
        chk("reg_split_first", r_y_split, 6'b001100);

        // Drive outputs to all ones.
        @(negedge clk);
        r_a_bus   = 6'b000000;
        r_a_split = 6'b000000;
        #1;
        chk("reg_bus_latency", r_y_bus, 6'b001100);
        @(posedge clk); #1;
        chk("reg_bus_ones", r_y_bus, 6'b111111);
        chk("reg_split_ones", r_y_split, 6'b111111);

        // Reset between edges clears immediately and holds across an edge.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_bus", r_y_bus, 6'b000000);
        chk("midrst_split", r_y_split, 6'b000000);
        @(posedge clk); #1;
        chk("midrst_hold_bus", r_y_bus, 6'b000000);
        chk("midrst_hold_split", r_y_split, 6'b000000);

        // Recapture after release.
        @(negedge clk);
        rst_n     = 1'b1;
        r_a_split = 6'b000000;
        r_a_bus   = 6'b010101;
        @(posedge clk); #1;
        chk("post_rst_split", r_y_split, 6'b111111);
        chk("post_rst_bus", r_y_bus, 6'b101010);

        clk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
